mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mips_pkg.sv | 29 ++
 rtl/mult_div_unit_if.sv | 33 +++
 rtl/mult_div_unit.sv | 164 ++++++++++++++++
 tb/tb_mult_div_unit.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multiply/divide unit.
//   op_e    : encoding of the op input (MULT, MULTU, DIV, DIVU)
//   state_e : sequencer states of the multiply/divide unit
package mips_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } state_e;

  // Signed variants are the ones with op[0] == 0.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // Divides are the ones with op[1] == 1.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Bundle of the request, HI/LO move and status signals of the multiply/divide
// unit.
//   master : the pipeline side (drives start/op/a/b/abort/hi_we/lo_we/wdata/rd_req)
//   slave  : the unit side (drives hi/lo/busy/done/div_zero/stall)
interface mult_div_unit_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  abort;
  logic                  hi_we;
  logic                  lo_we;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rd_req;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;
  logic                  busy;
  logic                  done;
  logic                  div_zero;
  logic                  stall;

  modport master (
    output start, op, a, b, abort, hi_we, lo_we, wdata, rd_req,
    input  hi, lo, busy, done, div_zero, stall
  );

  modport slave (
    input  start, op, a, b, abort, hi_we, lo_we, wdata, rd_req,
    output hi, lo, busy, done, div_zero, stall
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// One shift-add (multiply) or restoring shift-subtract (divide) step per
// clock for DATA_WIDTH clocks, then one sign-fix clock that writes HI/LO.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : mult_div_unit_if.slave -- start/op/a/b request, abort flush,
//           MTHI/MTLO writes (hi_we/lo_we/wdata), rd_req, and hi/lo/busy/
//           done/div_zero/stall outputs
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  mult_div_unit_if.slave   bus
);

  localparam int DW    = DATA_WIDTH;
  localparam int CNT_W = $clog2(DW) + 1;

  state_e state, state_next;

  // Shared accumulator: multiply keeps {partial product, remaining multiplier};
  // divide keeps {partial remainder, remaining dividend / quotient bits}.
  logic [2*DW-1:0]  acc;
  logic [DW-1:0]    opnd;        // |multiplicand| or |divisor|
  logic [CNT_W-1:0] count;
  logic             is_div;
  logic             neg_q;       // product / quotient must be negated
  logic             neg_r;       // remainder must be negated
  logic             div_by_zero;
  logic [DW-1:0]    hi_reg;
  logic [DW-1:0]    lo_reg;
  logic             done_reg;
  logic             dz_reg;

  // Request decode
  logic          start_ok;
  logic          sgn;
  logic          a_neg, b_neg;
  logic [DW-1:0] a_mag, b_mag;

  assign start_ok = (state == IDLE) && bus.start && !bus.abort;
  assign sgn      = op_is_signed(bus.op);
  assign a_neg    = sgn & bus.a[DW-1];
  assign b_neg    = sgn & bus.b[DW-1];
  assign a_mag    = a_neg ? -bus.a : bus.a;
  assign b_mag    = b_neg ? -bus.b : bus.b;

  // One multiply step: conditionally add, then shift right by one.
  logic [DW:0]     mul_sum;
  logic [2*DW-1:0] mul_step;
  assign mul_sum  = {1'b0, acc[2*DW-1:DW]} + (acc[0] ? {1'b0, opnd} : {(DW+1){1'b0}});
  assign mul_step = {mul_sum, acc[DW-1:1]};

  // One restoring divide step: shift left, trial-subtract, keep if no borrow.
  // The shifted remainder needs DW+1 bits since it can reach 2*divisor-1.
  logic [DW:0]     rem_sh;
  logic [DW:0]     diff;
  logic [2*DW-1:0] div_step;
  assign rem_sh   = acc[2*DW-1:DW-1];
  assign diff     = rem_sh - {1'b0, opnd};
  assign div_step = diff[DW] ? {rem_sh[DW-1:0], acc[DW-2:0], 1'b0}
                             : {diff[DW-1:0],   acc[DW-2:0], 1'b1};

  // Sign correction. With a zero divisor the restoring loop leaves |a| in
  // the remainder half, so the dividend-sign fix restores HI = a; LO is
  // forced to all ones.
  logic [2*DW-1:0] prod_fix;
  logic [DW-1:0]   q_fix, r_fix;
  assign prod_fix = neg_q ? -acc : acc;
  assign q_fix    = div_by_zero ? {DW{1'b1}}
                  : (neg_q ? -acc[DW-1:0] : acc[DW-1:0]);
  assign r_fix    = neg_r ? -acc[2*DW-1:DW] : acc[2*DW-1:DW];

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start_ok) state_next = CALC;
      CALC: begin
        if (bus.abort)                       state_next = IDLE;
        else if (count == CNT_W'(DW - 1))    state_next = FIX;
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Datapath and architectural registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc         <= '0;
      opnd        <= '0;
      count       <= '0;
      is_div      <= 1'b0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      div_by_zero <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      done_reg    <= 1'b0;
      dz_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      dz_reg   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.hi_we) hi_reg <= bus.wdata;
          if (bus.lo_we) lo_reg <= bus.wdata;
          if (start_ok) begin
            is_div      <= op_is_div(bus.op);
            neg_q       <= a_neg ^ b_neg;
            neg_r       <= a_neg;
            div_by_zero <= op_is_div(bus.op) && (bus.b == '0);
            count       <= '0;
            if (op_is_div(bus.op)) begin
              acc  <= {{DW{1'b0}}, a_mag};
              opnd <= b_mag;
            end else begin
              acc  <= {{DW{1'b0}}, b_mag};
              opnd <= a_mag;
            end
          end
        end
        CALC: begin
          if (!bus.abort) begin
            acc   <= is_div ? div_step : mul_step;
            count <= count + CNT_W'(1);
          end
        end
        FIX: begin
          if (!bus.abort) begin
            if (is_div) begin
              hi_reg <= r_fix;
              lo_reg <= q_fix;
            end else begin
              hi_reg <= prod_fix[2*DW-1:DW];
              lo_reg <= prod_fix[DW-1:0];
            end
            done_reg <= 1'b1;
            dz_reg   <= div_by_zero;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.hi       = hi_reg;
  assign bus.lo       = lo_reg;
  assign bus.busy     = (state == CALC) || (state == FIX);
  assign bus.done     = done_reg;
  assign bus.div_zero = dz_reg;
  assign bus.stall    = bus.busy && (bus.rd_req || bus.start || bus.hi_we || bus.lo_we);

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit (DATA_WIDTH = 32): products,
// quotients/remainders, divide by zero, latency/busy timing, abort, reset
// mid-operation, MTHI/MTLO writes and stall.
module tb_mult_div_unit;

  localparam int DW = 32;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  mult_div_unit_if #(.DATA_WIDTH(DW)) bus ();

  mult_div_unit #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at #1 after a rising edge with the unit idle. Returns the values
  // seen at the done sample, latency in clocks from the start edge, and the
  // number of sampled cycles with busy / stall high.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo, output logic dz,
                        output int lat, output int bcnt, output int scnt, output logic st_end);
    bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bcnt = int'(bus.busy);
    scnt = int'(bus.stall);
    lat = 0; dz = 1'b0; st_end = 1'b0;
    while (lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done) begin
        dz = bus.div_zero;
        st_end = bus.stall;
        break;
      end
      bcnt += int'(bus.busy);
      scnt += int'(bus.stall);
    end
    hi = bus.hi; lo = bus.lo;
  endtask

  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo, input logic exp_dz);
    logic [31:0] hi, lo;
    logic dz, st;
    int lat, bcnt, scnt;
    run_op(op, a, b, hi, lo, dz, lat, bcnt, scnt, st);
    $display("txn %s op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0b lat=%0d", tag, op, a, b, hi, lo, dz, lat);
    check({tag, ".hi"}, 64'(hi), 64'(exp_hi));
    check({tag, ".lo"}, 64'(lo), 64'(exp_lo));
    check({tag, ".dz"}, 64'(dz), 64'(exp_dz));
    check({tag, ".lat"}, 64'(lat), 64'd33);
  endtask

  initial begin
    logic [31:0] hi, lo;
    logic dz, st;
    int lat, bcnt, scnt, ndone;

    n_cmp = 0; n_bad = 0;
    reset = 1'b0;
    bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0; bus.abort = 0;
    bus.hi_we = 0; bus.lo_we = 0; bus.wdata = 0; bus.rd_req = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst.hi", 64'(bus.hi), 64'd0);
    check("rst.lo", 64'(bus.lo), 64'd0);
    check("rst.busy", 64'(bus.busy), 64'd0);
    check("rst.done", 64'(bus.done), 64'd0);
    check("rst.dz", 64'(bus.div_zero), 64'd0);
    reset = 1'b1;

    // MULT -3*7: start taken at the first edge after reset release
    run_op(2'b00, 32'hFFFFFFFD, 32'd7, hi, lo, dz, lat, bcnt, scnt, st);
    $display("txn mult op=0 a=fffffffd b=00000007 -> hi=%h lo=%h lat=%0d busy=%0d", hi, lo, lat, bcnt);
    check("mult.hi", 64'(hi), 64'hFFFFFFFF);
    check("mult.lo", 64'(lo), 64'hFFFFFFEB);
    check("mult.lat", 64'(lat), 64'd33);
    check("mult.busy_cycles", 64'(bcnt), 64'd33);
    check("mult.dz", 64'(dz), 64'd0);
    @(posedge clk); #1;
    check("mult.done_pulse", 64'(bus.done), 64'd0);

    do_op("divu100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    do_op("div-7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    do_op("div7_-2", 2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0);
    do_op("div_min_-1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0);
    do_op("div5_0", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1);
    do_op("div-5_0", 2'b10, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);
    do_op("divu_big_0", 2'b11, 32'hF0000001, 32'd0, 32'hF0000001, 32'hFFFFFFFF, 1'b1);
    do_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    do_op("mult_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0);
    do_op("mult_min_min", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
    do_op("divu_max_3", 2'b11, 32'hFFFFFFFF, 32'd3, 32'd0, 32'h55555555, 1'b0);

    // Stall: rd_req held high through an operation
    bus.rd_req = 1'b1;
    #1;
    check("stall.idle", 64'(bus.stall), 64'd0);
    run_op(2'b11, 32'd100, 32'd7, hi, lo, dz, lat, bcnt, scnt, st);
    $display("txn stall op=3 -> stall_cycles=%0d stall_at_done=%0b", scnt, st);
    check("stall.cycles", 64'(scnt), 64'd33);
    check("stall.at_done", 64'(st), 64'd0);
    bus.rd_req = 1'b0;

    // MTHI/MTLO in idle, then together with start (result overwrites)
    bus.hi_we = 1'b1; bus.wdata = 32'h00001234;
    @(posedge clk); #1;
    bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wdata = 32'h00005678;
    @(posedge clk); #1;
    bus.lo_we = 1'b0;
    $display("txn mthi/mtlo -> hi=%h lo=%h", bus.hi, bus.lo);
    check("mthi", 64'(bus.hi), 64'h1234);
    check("mtlo", 64'(bus.lo), 64'h5678);

    bus.hi_we = 1'b1; bus.wdata = 32'hCAFE0000;
    bus.op = 2'b01; bus.a = 32'd6; bus.b = 32'd7; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.hi_we = 1'b0; bus.start = 1'b0;
    check("mthi_start.hi", 64'(bus.hi), 64'hCAFE0000);
    // Second start and MTHI mid-run must be ignored
    repeat (5) @(posedge clk);
    #1;
    bus.op = 2'b11; bus.a = 32'd100; bus.b = 32'd7; bus.start = 1'b1;
    bus.hi_we = 1'b1; bus.wdata = 32'hDEADBEEF;
    #1;
    check("busy.stall_start", 64'(bus.stall), 64'd1);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.hi_we = 1'b0;
    lat = 6;
    while (lat < 100 && !bus.done) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("txn multu6_7 overlap -> hi=%h lo=%h lat=%0d", bus.hi, bus.lo, lat);
    check("overlap.lat", 64'(lat), 64'd33);
    check("overlap.hi", 64'(bus.hi), 64'd0);
    check("overlap.lo", 64'(bus.lo), 64'd42);
    @(posedge clk); #1;
    check("overlap.no_requeue", 64'(bus.busy), 64'd0);

    // Abort during CALC: HI/LO hold, no done
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hA5A5A5A5;
    @(posedge clk); #1;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    bus.op = 2'b01; bus.a = 32'hFFFF; bus.b = 32'hFFFF; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    $display("txn abort -> busy=%0b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
    check("abort.busy", 64'(bus.busy), 64'd0);
    check("abort.hi", 64'(bus.hi), 64'hA5A5A5A5);
    check("abort.lo", 64'(bus.lo), 64'hA5A5A5A5);
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      ndone += int'(bus.done);
    end
    check("abort.no_done", 64'(ndone), 64'd0);

    // Abort together with start in idle cancels the start
    bus.start = 1'b1; bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    check("abort_start.busy", 64'(bus.busy), 64'd0);

    // Reset during CALC
    bus.op = 2'b00; bus.a = 32'd9; bus.b = 32'd9; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    $display("txn reset_mid -> busy=%0b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
    check("rst_mid.hi", 64'(bus.hi), 64'd0);
    check("rst_mid.lo", 64'(bus.lo), 64'd0);
    check("rst_mid.busy", 64'(bus.busy), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      ndone += int'(bus.done);
    end
    check("rst_mid.no_done", 64'(ndone), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
